// File: rtl/dmem_loader_pkg.sv
// Shared constants for the boot-time data-memory loader: FSM encoding,
// word geometry and the word-counter width helper.
package dmem_loader_pkg;

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_DATA  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_GAP   = 3'd4,
    S_CHK   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam int BYTES_PER_WORD    = 4;
  localparam int MAX_WORDS_DEFAULT = 65536;

  function automatic int cnt_width(input int max_words);
    return $clog2(max_words + 1);
  endfunction

  localparam int WORD_CNT_W = cnt_width(MAX_WORDS_DEFAULT);

endpackage

// File: rtl/m_dmem_loader_byte_assembler.sv
// One-byte holding register feeding a 32-bit little-endian shifter.
// Used for both the word-count header and the payload words.
module m_byte_assembler
  import dmem_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  input  logic        i_accept,
  output logic        o_drain,
  output logic        o_word_ready,
  output logic [31:0] o_word,
  output logic        o_overrun
);

  logic        hold_valid;
  logic [7:0]  hold_byte;
  logic [1:0]  idx;
  logic [31:0] shreg;
  logic [7:0]  cur_byte;

  // A byte drains straight through when the holding register is empty, so
  // o_word[31:24] is always the byte being consumed this cycle.
  always_comb begin
    cur_byte     = hold_valid ? hold_byte : i_rx_data;
    o_drain      = (hold_valid | i_rx_valid) & i_accept;
    o_word       = {cur_byte, shreg[31:8]};
    o_word_ready = o_drain & (idx == 2'(BYTES_PER_WORD - 1));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_valid <= 1'b0;
      hold_byte  <= 8'h00;
      idx        <= 2'd0;
      shreg      <= 32'h0;
      o_overrun  <= 1'b0;
    end else begin
      if (o_drain) begin
        shreg <= o_word;
        idx   <= idx + 2'd1;
      end
      if (hold_valid) begin
        if (o_drain) begin
          hold_valid <= i_rx_valid;
          hold_byte  <= i_rx_data;
        end else if (i_rx_valid) begin
          o_overrun <= 1'b1;
        end
      end else if (i_rx_valid && !i_accept) begin
        hold_valid <= 1'b1;
        hold_byte  <= i_rx_data;
      end
    end
  end

endmodule

// File: rtl/m_dmem_loader.sv
// Boot loader: UART byte stream -> word writes on the dmem init port.
// Build option DMEM_LOADER_CHECKSUM_EN adds an XOR trailer byte and o_cksum_err.
module m_dmem_loader
  import dmem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          MAX_WORDS  = MAX_WORDS_DEFAULT,
  parameter int          GAP_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  input  logic        i_mem_stall,
  output logic [3:0]  o_init_wen,
  output logic [31:0] o_init_addr,
  output logic [31:0] o_init_data,
  output logic        o_init_done,
  output logic        o_overrun,
  output logic        o_busy,
  output logic [2:0]  o_dbg_state
`ifdef DMEM_LOADER_CHECKSUM_EN
  ,
  output logic        o_cksum_err
`endif
);

  localparam int CW = cnt_width(MAX_WORDS);
  localparam int GW = $clog2(GAP_CYCLES + 2);

  state_t        state;
  logic [CW-1:0] count;
  logic [CW-1:0] word_cnt;
  logic [GW-1:0] gap_cnt;
  logic [31:0]   nxt_data;
  logic          nxt_valid;
  logic          accept;
  logic          more;
  logic          drain;
  logic          word_ready;
  logic [31:0]   word;
  logic [CW-1:0] hdr_clamped;
`ifdef DMEM_LOADER_CHECKSUM_EN
  logic [7:0]    cksum;
`endif

  m_byte_assembler u_asm (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rx_valid   (i_rx_valid),
    .i_rx_data    (i_rx_data),
    .i_accept     (accept),
    .o_drain      (drain),
    .o_word_ready (word_ready),
    .o_word       (word),
    .o_overrun    (o_overrun)
  );

  // Payload bytes are taken while a write is pending only if another word is
  // still owed and the next-word register is free; anything beyond waits.
  always_comb begin
    more = 1'b0;
    case (state)
      S_WAIT, S_WRITE: more = (word_cnt + CW'(1)) < count;
      S_GAP:           more = word_cnt < count;
      default:         more = 1'b0;
    endcase
    accept = 1'b1;
    if (state inside {S_WAIT, S_WRITE, S_GAP}) accept = more & ~nxt_valid;
    hdr_clamped = (word > 32'(MAX_WORDS)) ? CW'(MAX_WORDS) : word[CW-1:0];
  end

  assign o_dbg_state = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_HDR;
      count       <= '0;
      word_cnt    <= '0;
      gap_cnt     <= '0;
      nxt_data    <= 32'h0;
      nxt_valid   <= 1'b0;
      o_init_wen  <= 4'h0;
      o_init_addr <= BASE_ADDR;
      o_init_data <= 32'h0;
      o_init_done <= 1'b0;
      o_busy      <= 1'b0;
`ifdef DMEM_LOADER_CHECKSUM_EN
      cksum       <= 8'h00;
      o_cksum_err <= 1'b0;
`endif
    end else begin
`ifdef DMEM_LOADER_CHECKSUM_EN
      if (drain && (state inside {S_DATA, S_WAIT, S_WRITE, S_GAP}))
        cksum <= cksum ^ word[31:24];
`endif
      case (state)
        S_HDR: begin
          if (drain) o_busy <= 1'b1;
          if (word_ready) begin
            count <= hdr_clamped;
            if (hdr_clamped == '0) begin
              state       <= S_DONE;
              o_init_done <= 1'b1;
              o_busy      <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (word_ready) begin
            o_init_data <= word;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (word_ready) begin
            nxt_data  <= word;
            nxt_valid <= 1'b1;
          end
          if (!i_mem_stall) begin
            o_init_wen <= 4'hF;
            state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (word_ready) begin
            nxt_data  <= word;
            nxt_valid <= 1'b1;
          end
          o_init_wen  <= 4'h0;
          o_init_addr <= o_init_addr + 32'd4;
          word_cnt    <= word_cnt + CW'(1);
          gap_cnt     <= GW'(GAP_CYCLES);
          state       <= S_GAP;
        end
        S_GAP: begin
          if (word_ready) begin
            nxt_data  <= word;
            nxt_valid <= 1'b1;
          end
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
          end else if (!i_mem_stall) begin
            if (word_cnt == count) begin
`ifdef DMEM_LOADER_CHECKSUM_EN
              state <= S_CHK;
`else
              state       <= S_DONE;
              o_init_done <= 1'b1;
              o_busy      <= 1'b0;
`endif
            end else if (nxt_valid) begin
              o_init_data <= nxt_data;
              nxt_valid   <= 1'b0;
              state       <= S_WAIT;
            end else if (word_ready) begin
              // Word completed on the exit cycle: bypass the next-word register.
              o_init_data <= word;
              nxt_valid   <= 1'b0;
              state       <= S_WAIT;
            end else begin
              state <= S_DATA;
            end
          end
        end
`ifdef DMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (drain) begin
            if (word[31:24] != cksum) o_cksum_err <= 1'b1;
            state       <= S_DONE;
            o_init_done <= 1'b1;
            o_busy      <= 1'b0;
          end
        end
`endif
        S_DONE: begin
          o_init_done <= 1'b1;
          o_busy      <= 1'b0;
        end
        default: state <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_m_dmem_loader.sv
// Directed bench for m_dmem_loader: write scoreboard fed by the stimulus,
// drained by a negedge monitor on the init write port.
module tb_m_dmem_loader;
  import dmem_loader_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          GAP  = 2;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        i_mem_stall;
  logic [3:0]  o_init_wen;
  logic [31:0] o_init_addr;
  logic [31:0] o_init_data;
  logic        o_init_done;
  logic        o_overrun;
  logic        o_busy;
  logic [2:0]  o_dbg_state;
`ifdef DMEM_LOADER_CHECKSUM_EN
  logic        o_cksum_err;
`endif

  m_dmem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(65536), .GAP_CYCLES(GAP)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rx_valid  (i_rx_valid),
    .i_rx_data   (i_rx_data),
    .i_mem_stall (i_mem_stall),
    .o_init_wen  (o_init_wen),
    .o_init_addr (o_init_addr),
    .o_init_data (o_init_data),
    .o_init_done (o_init_done),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy),
    .o_dbg_state (o_dbg_state)
`ifdef DMEM_LOADER_CHECKSUM_EN
    ,
    .o_cksum_err (o_cksum_err)
`endif
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];   // {addr, data} of each expected write
  logic        seen_write;
  int          idle_cnt;
  logic        stall_at_edge;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_reset();
    i_rst_n     = 1'b0;
    i_rx_valid  = 1'b0;
    i_rx_data   = 8'h00;
    i_mem_stall = 1'b0;
    exp_q.delete();
    seen_write  = 1'b0;
    idle_cnt    = 0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(posedge i_clk);
    #1 i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] t;
      t = w >> (8 * i);
      send_byte(t[7:0]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !o_init_done; i++) begin
      @(posedge i_clk);
      #1;
    end
    check("done_within_budget", o_init_done, 1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge i_clk) stall_at_edge <= i_mem_stall;

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_init_wen != 4'h0) begin
        check("wen_value", o_init_wen, 4'hF);
        check("stall_low_at_issue", stall_at_edge, 0);
        check("done_low_at_write", o_init_done, 0);
        if (seen_write) check("gap_idle_cycles", (idle_cnt >= GAP), 1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: addr %0h data %0h, expected no write", o_init_addr, o_init_data);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("write_addr", o_init_addr, e[63:32]);
          check("write_data", o_init_data, e[31:0]);
        end
        seen_write = 1'b1;
        idle_cnt   = 0;
      end else begin
        idle_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    apply_reset();

    // reset state
    check("rst_wen", o_init_wen, 0);
    check("rst_addr", o_init_addr, BASE);
    check("rst_data", o_init_data, 0);
    check("rst_done", o_init_done, 0);
    check("rst_overrun", o_overrun, 0);
    check("rst_busy", o_busy, 0);
    check("rst_state", o_dbg_state, S_HDR);

    // two words, no stall
    exp_q.push_back({BASE, 32'h4433_2211});
    exp_q.push_back({BASE + 32'd4, 32'h8877_6655});
    send_byte(8'h02);
    check("busy_after_first_byte", o_busy, 1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_word(32'h4433_2211);
    send_word(32'h8877_6655);
    wait_done(100);
    check("two_word_busy_low", o_busy, 0);
    check("two_word_state", o_dbg_state, S_DONE);
    check("two_word_all_written", exp_q.size(), 0);
    check("two_word_overrun", o_overrun, 0);
    send_byte(8'hAA); send_byte(8'hBB); idle(5);
    check("done_ignores_bytes_overrun", o_overrun, 0);
    check("done_sticky", o_init_done, 1);

    // zero word count
    apply_reset();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("zero_done_before_4th", o_init_done, 0);
    send_byte(8'h00);
    check("zero_done_after_4th", o_init_done, 1);
    idle(10);
    check("zero_no_writes", exp_q.size(), 0);

    // stall held 20 cycles while word 0 is ready
    apply_reset();
    i_mem_stall = 1'b1;
    exp_q.push_back({BASE, 32'hCAFE_F00D});
    send_word(32'h0000_0001);
    send_word(32'hCAFE_F00D);
    idle(20);
    check("stall_no_write_yet", exp_q.size(), 1);
    check("stall_data_stable", o_init_data, 32'hCAFE_F00D);
    check("stall_addr_stable", o_init_addr, BASE);
    i_mem_stall = 1'b0;
    @(posedge i_clk); #1;
    check("write_cycle_after_stall", o_init_wen, 4'hF);
    wait_done(50);
    check("stall_all_written", exp_q.size(), 0);

    // overrun: stream back-to-back while stalled
    apply_reset();
    i_mem_stall = 1'b1;
    exp_q.push_back({BASE, 32'h1312_1110});
    exp_q.push_back({BASE + 32'd4, 32'h1716_1514});
    send_word(32'h0000_0003);
    send_word(32'h1312_1110);
    send_word(32'h1716_1514);
    check("overrun_clear_within_slack", o_overrun, 0);
    send_word(32'h1B1A_1918);
    check("overrun_set", o_overrun, 1);
    idle(3);
    i_mem_stall = 1'b0;
    idle(40);
    check("overrun_earlier_words_written", exp_q.size(), 0);
    check("overrun_not_done", o_init_done, 0);

    // reset mid-payload, then resend the full stream
    apply_reset();
    send_word(32'h0000_0001);
    send_byte(8'hEF); send_byte(8'hBE);
    i_rst_n = 1'b0;
    #1;
    check("midrst_wen", o_init_wen, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_addr", o_init_addr, BASE);
    check("midrst_done", o_init_done, 0);
    apply_reset();
    exp_q.push_back({BASE, 32'hDEAD_BEEF});
    send_word(32'h0000_0001);
    send_word(32'hDEAD_BEEF);
    wait_done(50);
    check("resend_all_written", exp_q.size(), 0);

`ifdef DMEM_LOADER_CHECKSUM_EN
    apply_reset();
    exp_q.push_back({BASE, 32'h0804_0201});
    send_word(32'h0000_0001);
    send_word(32'h0804_0201);
    send_byte(8'h0F);
    wait_done(50);
    check("cksum_good_err", o_cksum_err, 0);
    check("cksum_good_written", exp_q.size(), 0);

    apply_reset();
    exp_q.push_back({BASE, 32'h0804_0201});
    send_word(32'h0000_0001);
    send_word(32'h0804_0201);
    send_byte(8'h00);
    wait_done(50);
    check("cksum_bad_err", o_cksum_err, 1);
    check("cksum_bad_written", exp_q.size(), 0);
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
